dvi_init_sequencer: RTL
=======================

Name: dvi_init_sequencer

Overview:
- Brings up the DVI transmitter path after reset or PLL lock loss: holds video/DVI reset, waits for PLL lock, releases reset, waits a settle time, then writes a fixed register table into the DVI encoder chip through the existing byte-level TWI master using a req/done handshake.
- Reports progress and failure to the system GPIO status word.
- Re-runs automatically on lock loss or on software start.

Parameters:
- DEV_ADDR, 7'h76, 7-bit TWI device address of the DVI encoder.
- RST_CYCLES, 1000, clocks oDviRst is held asserted after lock.
- SETTLE_CYCLES, 100000, clocks waited after reset release before the first TWI write.
- MAX_RETRY, 3, retries per table entry after iTwiErr before FAIL.

Ports:
- iClk  in  1  system clock
- iRst_neg  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse; restarts the sequence from WAIT_LOCK
- iPllLocked  in  1  video PLL lock, already synchronised to iClk
- oDviRst  out  1  active-high reset to the DVI converter/chip
- oTwiReq  out  1  transaction request, held until iTwiDone
- oTwiDevAddr  out  7  device address (constant DEV_ADDR)
- oTwiRegAddr  out  8  register address
- oTwiWrData  out  8  write data
- oTwiRnw  out  1  1 = read, 0 = write
- iTwiDone  in  1  one-cycle pulse; transaction finished
- iTwiErr  in  1  valid with iTwiDone; NACK or arbitration loss
- iTwiRdData  in  8  read data, valid with iTwiDone
- oBusy  out  1  sequence in progress
- oReady  out  1  table written successfully
- oFail  out  1  retries exhausted
- oIndex  out  3  current table entry

Behaviour:
- Reset values: oDviRst=1, oTwiReq=0, oTwiRnw=0, oTwiRegAddr=0, oTwiWrData=0, oBusy=0, oReady=0, oFail=0, oIndex=0. State after reset is WAIT_LOCK. oTwiDevAddr is always DEV_ADDR.
- The table is fixed, 8 entries {reg,data}:
  - 0:{1C,04}, 1:{1D,45}, 2:{1F,80}, 3:{21,09}
  - 4:{33,08}, 5:{34,16}, 6:{36,60}, 7:{49,C0}
- States:
  - WAIT_LOCK: oDviRst=1, oBusy=1. On iPllLocked=1 → RST_HOLD with the counter cleared.
  - RST_HOLD: oDviRst=1. Counter runs to RST_CYCLES-1, then → SETTLE. oDviRst goes to 0 on the cycle SETTLE is entered.
  - SETTLE: counter runs to SETTLE_CYCLES-1, then → ISSUE with index=0 and retry=0.
  - ISSUE: drive reg/data from table[index], set oTwiReq=1 → WAIT_DONE. Latency is 1 clk from state entry to oTwiReq.
  - WAIT_DONE: hold oTwiReq and all address/data outputs stable until iTwiDone.
    - iTwiDone & !iTwiErr → NEXT.
    - iTwiDone & iTwiErr & retry<MAX_RETRY → retry+1, → ISSUE.
    - iTwiDone & iTwiErr & retry==MAX_RETRY → FAIL.
    - oTwiReq drops in the cycle after iTwiDone.
  - NEXT: index==7 → DONE. Otherwise index+1, retry=0, → ISSUE.
  - DONE: oReady=1, oBusy=0, oDviRst=0.
  - FAIL: oFail=1, oBusy=0, oDviRst=0. oIndex holds the failing entry.
- Lock loss: iPllLocked=0 in any state other than WAIT_LOCK:
  - The next state is WAIT_LOCK. oDviRst=1 the following cycle. oReady, oFail and the counter are cleared. index is reset to 0.
  - If this happens in WAIT_DONE, oTwiReq drops immediately and any late iTwiDone is ignored.
- iStart in any state → WAIT_LOCK with the same clears as lock loss. Lock loss and iStart together behave as a single restart.
- iTwiDone outside WAIT_DONE is ignored.
- Counter width is clog2(max(RST_CYCLES,SETTLE_CYCLES)). The counter saturates and never wraps.
- Retry counter width is clog2(MAX_RETRY+1).

Optional Feature:
- Macro: DVI_INIT_VERIFY_EN.
- Defined:
  - After each successful write, a VERIFY state issues a read (oTwiRnw=1) of the same register.
  - On iTwiDone & !iTwiErr: if iTwiRdData==data → NEXT. A mismatch counts as an error.
  - A read iTwiErr also counts as an error.
  - Errors use the shared retry counter. A retry re-issues the write, not only the read.
- Not defined: oTwiRnw is tied 0, the VERIFY state does not exist, and iTwiRdData is unused.

Test Plan:
- Reset, iPllLocked=1, RST_CYCLES=4, SETTLE_CYCLES=8, iTwiDone 3 clks after each req, no error → oDviRst falls 4 clks after lock; first oTwiReq carries reg 1C / data 04; 8 writes in table order; oReady=1, oIndex=7.
- Error on entry 2 twice, then success → entry 2 is issued 3 times with identical outputs; sequence completes; oFail=0.
- Error on entry 5 four times with MAX_RETRY=3 → oFail=1, oIndex=5, no further oTwiReq, oDviRst=0.
- iPllLocked drops while in WAIT_DONE at entry 3 → oTwiReq=0 next clk, oDviRst=1, oReady=0; a late iTwiDone is ignored; on relock the sequence restarts at entry 0.
- iStart pulse after DONE → oReady clears, oBusy=1, oDviRst=1, full table is rewritten.
- DVI_INIT_VERIFY_EN defined, readback of entry 7 returns 0x80 → write is retried; a correct readback of 0xC0 then gives oReady=1.

Source files
------------

// File: rtl/dvi_init_sequencer.sv
// DVI transmitter bring-up: holds the chip in reset until PLL lock, then writes the encoder register table over TWI.
// Define DVI_INIT_VERIFY_EN to read back and compare every register after it is written.
module dvi_init_sequencer #(
    parameter logic [6:0] DEV_ADDR      = 7'h76,
    parameter int         RST_CYCLES    = 1000,
    parameter int         SETTLE_CYCLES = 100000,
    parameter int         MAX_RETRY     = 3
) (
    input  logic       iClk,
    input  logic       iRst_neg,
    input  logic       iStart,
    input  logic       iPllLocked,
    output logic       oDviRst,
    output logic       oTwiReq,
    output logic [6:0] oTwiDevAddr,
    output logic [7:0] oTwiRegAddr,
    output logic [7:0] oTwiWrData,
    output logic       oTwiRnw,
    input  logic       iTwiDone,
    input  logic       iTwiErr,
    input  logic [7:0] iTwiRdData,
    output logic       oBusy,
    output logic       oReady,
    output logic       oFail,
    output logic [2:0] oIndex
);

    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_LAST  = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_WAIT_LOCK,
        S_RST_HOLD,
        S_SETTLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE,
        S_FAIL
`ifdef DVI_INIT_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    // Encoder register table, {register, data}.
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = 16'h1C04;
            3'd1:    table_entry = 16'h1D45;
            3'd2:    table_entry = 16'h1F80;
            3'd3:    table_entry = 16'h2109;
            3'd4:    table_entry = 16'h3308;
            3'd5:    table_entry = 16'h3416;
            3'd6:    table_entry = 16'h3660;
            default: table_entry = 16'h49C0;
        endcase
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retry;
    logic             r_rnw;

    logic [15:0]      w_entry;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_restart;
    logic             w_xfer_err;
    state_t           w_ok_next;

    assign oTwiDevAddr = DEV_ADDR;
    assign w_entry     = table_entry(oIndex);
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_restart   = iStart | (~iPllLocked & (r_state != S_WAIT_LOCK));

`ifdef DVI_INIT_VERIFY_EN
    // A readback that differs from what was written is handled exactly like a NACK.
    assign w_xfer_err = iTwiErr | (r_rnw & (iTwiRdData != oTwiWrData));
    assign w_ok_next  = r_rnw ? S_NEXT : S_VERIFY;
    assign oTwiRnw    = r_rnw;
`else
    logic w_rd_unused;
    assign w_rd_unused = ^{iTwiRdData, r_rnw};
    assign w_xfer_err  = iTwiErr;
    assign w_ok_next   = S_NEXT;
    assign oTwiRnw     = 1'b0;
`endif

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments only, so every output is a clean register.
    always_ff @(posedge iClk or negedge iRst_neg) begin
        if (!iRst_neg) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_rnw       <= 1'b0;
            oDviRst     <= 1'b1;
            oTwiReq     <= 1'b0;
            oTwiRegAddr <= 8'h00;
            oTwiWrData  <= 8'h00;
            oBusy       <= 1'b0;
            oReady      <= 1'b0;
            oFail       <= 1'b0;
            oIndex      <= 3'd0;
        end else if (w_restart) begin
            // Lock loss or software start; a pending TWI completion is abandoned.
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_retry <= '0;
            r_rnw   <= 1'b0;
            oDviRst <= 1'b1;
            oTwiReq <= 1'b0;
            oBusy   <= 1'b1;
            oReady  <= 1'b0;
            oFail   <= 1'b0;
            oIndex  <= 3'd0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    oDviRst <= 1'b1;
                    oBusy   <= 1'b1;
                    if (iPllLocked) begin
                        r_cnt   <= '0;
                        r_state <= S_RST_HOLD;
                    end
                end
                S_RST_HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt   <= '0;
                        oDviRst <= 1'b0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        oIndex  <= 3'd0;
                        r_retry <= '0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ISSUE: begin
                    oTwiRegAddr <= w_entry[15:8];
                    oTwiWrData  <= w_entry[7:0];
                    r_rnw       <= 1'b0;
                    oTwiReq     <= 1'b1;
                    r_state     <= S_WAIT_DONE;
                end
`ifdef DVI_INIT_VERIFY_EN
                S_VERIFY: begin
                    r_rnw   <= 1'b1;
                    oTwiReq <= 1'b1;
                    r_state <= S_WAIT_DONE;
                end
`endif
                S_WAIT_DONE: begin
                    if (iTwiDone) begin
                        oTwiReq <= 1'b0;
                        if (!w_xfer_err) begin
                            r_state <= w_ok_next;
                        end else if (r_retry == RETRY_LAST) begin
                            oFail   <= 1'b1;
                            oBusy   <= 1'b0;
                            oDviRst <= 1'b0;
                            r_state <= S_FAIL;
                        end else begin
                            // Any failure, including a bad readback, re-issues the write.
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_NEXT: begin
                    if (oIndex == 3'd7) begin
                        oReady  <= 1'b1;
                        oBusy   <= 1'b0;
                        oDviRst <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        oIndex  <= oIndex + 3'd1;
                        r_retry <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE, S_FAIL: begin
                    r_state <= r_state;
                end
                default: r_state <= S_WAIT_LOCK;
            endcase
        end
    end

endmodule
